sd_xfer_sequencer: RTL and testbench

//  Host-clock controller that sequences one SD transaction across the CMD and DAT engines: issues the command,

---
 rtl/sd_xfer_sequencer_pkg.sv | 43 ++++
 rtl/sd_xfer_sequencer_timeout.sv | 43 ++++
 rtl/sd_xfer_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sd_xfer_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_xfer_sequencer_pkg.sv
// Shared definitions for the SD transaction sequencer: state encodings, error bit positions, CMD12 index.
// Build option AUTO_CMD12_EN adds the automatic stop-command states.
package sd_xfer_sequencer_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_CMD_SEND  = 4'd1;
  localparam logic [3:0] ST_CMD_WAIT  = 4'd2;
  localparam logic [3:0] ST_DAT_START = 4'd3;
  localparam logic [3:0] ST_DAT_WAIT  = 4'd4;
  localparam logic [3:0] ST_GAP       = 4'd5;
  localparam logic [3:0] ST_DONE      = 4'd6;
  localparam logic [3:0] ST_ERR       = 4'd7;
  localparam logic [3:0] ST_STOP_SEND = 4'd8;
  localparam logic [3:0] ST_STOP_WAIT = 4'd9;

  typedef enum logic [3:0] {
    S_IDLE      = ST_IDLE,
    S_CMD_SEND  = ST_CMD_SEND,
    S_CMD_WAIT  = ST_CMD_WAIT,
    S_DAT_START = ST_DAT_START,
    S_DAT_WAIT  = ST_DAT_WAIT,
    S_GAP       = ST_GAP,
    S_DONE      = ST_DONE,
    S_ERR       = ST_ERR
`ifdef AUTO_CMD12_EN
    ,
    S_STOP_SEND = ST_STOP_SEND,
    S_STOP_WAIT = ST_STOP_WAIT
`endif
  } state_e;

  localparam int unsigned ERR_CMD_TMO = 0;
  localparam int unsigned ERR_DAT_CRC = 1;
  localparam int unsigned ERR_DAT_TMO = 2;

  localparam logic [5:0] CMD12_INDEX = 6'd12;

  // States during which the DAT path is owned by this transaction.
  function automatic logic is_dat_state(input state_e s);
    return (s == S_DAT_START) || (s == S_DAT_WAIT) || (s == S_GAP);
  endfunction

endpackage

// File: rtl/sd_xfer_sequencer_timeout.sv
// sd_xfer_timeout: loadable down-counter guarding one data block; expires when it reaches zero.
module sd_xfer_timeout #(
  parameter int unsigned TMO = 4096,
  parameter int unsigned W   = $clog2(TMO + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [W-1:0] LOAD_VAL = W'(TMO - 1);
  localparam logic [W-1:0] CNT_ONE  = W'(1);
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Loading TMO-1 makes expiry land on the TMO-th enabled cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/sd_xfer_sequencer.sv
// sd_xfer_sequencer: sequences one SD transaction (command, response, block-by-block data) between CMD and DAT.
// Build option AUTO_CMD12_EN issues CMD12 automatically after the last block of a multi-block transfer.
module sd_xfer_sequencer
  import sd_xfer_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DAT_TMO = 4096
) (
  input  logic             host_clk,
  input  logic             rst_L,
  input  logic             start,
  input  logic [5:0]       cmd_index,
  input  logic [31:0]      cmd_arg,
  input  logic             has_data,
  input  logic             dir_read,
  input  logic             multi_blk,
  input  logic [CNT_W-1:0] block_cnt,
  input  logic             stop_at_gap,
  input  logic             continue_req,
  input  logic             cmd_complete,
  input  logic             cmd_timeout,
  input  logic             dat_blk_done,
  input  logic             dat_crc_err,
  output logic             cmd_issue,
  output logic [5:0]       cmd_index_out,
  output logic [31:0]      cmd_arg_out,
  output logic             tx_data_init,
  output logic             rx_data_init,
  output logic             cmd_inhibit,
  output logic             dat_active,
  output logic [CNT_W-1:0] blocks_left,
  output logic             xfer_done,
  output logic             gap_evt,
  output logic [2:0]       err_code
);

  localparam logic [CNT_W-1:0] BLK_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] BLK_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [31:0]      arg_q, arg_d;
  logic             has_data_q, has_data_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] blocks_q, blocks_d;
  logic [2:0]       err_q, err_d;
`ifdef AUTO_CMD12_EN
  logic             auto_stop_q, auto_stop_d;
`endif

  logic cmd_issue_q, tx_init_q, rx_init_q, inhibit_q, dat_active_q, xfer_done_q, gap_evt_q;
  logic issue_s, tmo_load_s, tmo_en_s, tmo_exp_s;

  sd_xfer_timeout #(
    .TMO (DAT_TMO)
  ) u_tmo (
    .clk_i     (host_clk),
    .rst_ni    (rst_L),
    .load_i    (tmo_load_s),
    .en_i      (tmo_en_s),
    .expired_o (tmo_exp_s)
  );

  // Next-state, transaction latches, block counter and error accumulation.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    has_data_d = has_data_q;
    dir_d      = dir_q;
    blocks_d   = blocks_q;
    err_d      = err_q;
    tmo_load_s = 1'b0;
    tmo_en_s   = 1'b0;
`ifdef AUTO_CMD12_EN
    auto_stop_d = auto_stop_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CMD_SEND;
          idx_d      = cmd_index;
          arg_d      = cmd_arg;
          has_data_d = has_data;
          dir_d      = dir_read;
          blocks_d   = multi_blk ? block_cnt : BLK_ONE;
          err_d      = 3'b000;
`ifdef AUTO_CMD12_EN
          auto_stop_d = multi_blk;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMD_SEND: begin
        state_d = S_CMD_WAIT;
      end
      S_CMD_WAIT: begin
        if (cmd_timeout) begin
          state_d             = S_ERR;
          err_d[ERR_CMD_TMO]  = 1'b1;
        end else if (cmd_complete) begin
          if (has_data_q && (blocks_q != BLK_ZERO)) begin
            state_d = S_DAT_START;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_CMD_WAIT;
        end
      end
      S_DAT_START: begin
        tmo_load_s = 1'b1;
        state_d    = S_DAT_WAIT;
      end
      S_DAT_WAIT: begin
        tmo_en_s = 1'b1;
        // A CRC error on the same cycle as block-done discards that block.
        if (dat_crc_err) begin
          state_d            = S_ERR;
          err_d[ERR_DAT_CRC] = 1'b1;
        end else if (tmo_exp_s) begin
          state_d            = S_ERR;
          err_d[ERR_DAT_TMO] = 1'b1;
        end else if (dat_blk_done) begin
          if (blocks_q != BLK_ZERO) begin
            blocks_d = blocks_q - BLK_ONE;
          end else begin
            blocks_d = blocks_q;
          end
          if (blocks_d == BLK_ZERO) begin
`ifdef AUTO_CMD12_EN
            if (auto_stop_q) begin
              state_d = S_STOP_SEND;
              idx_d   = CMD12_INDEX;
              arg_d   = 32'h0000_0000;
            end else begin
              state_d = S_DONE;
            end
`else
            state_d = S_DONE;
`endif
          end else if (stop_at_gap) begin
            state_d = S_GAP;
          end else begin
            state_d = S_DAT_START;
          end
        end else begin
          state_d = S_DAT_WAIT;
        end
      end
      S_GAP: begin
        if (continue_req) begin
          state_d = S_DAT_START;
        end else begin
          state_d = S_GAP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
`ifdef AUTO_CMD12_EN
      S_STOP_SEND: begin
        state_d = S_STOP_WAIT;
      end
      S_STOP_WAIT: begin
        if (cmd_timeout) begin
          state_d            = S_ERR;
          err_d[ERR_CMD_TMO] = 1'b1;
        end else if (cmd_complete) begin
          state_d = S_DONE;
        end else begin
          state_d = S_STOP_WAIT;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Command issue strobe follows entry into either command-send state.
  always_comb begin
`ifdef AUTO_CMD12_EN
    issue_s = (state_d == S_CMD_SEND) || (state_d == S_STOP_SEND);
`else
    issue_s = (state_d == S_CMD_SEND);
`endif
  end

  // State and transaction latches.
  always_ff @(posedge host_clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q    <= S_IDLE;
      idx_q      <= 6'd0;
      arg_q      <= 32'h0000_0000;
      has_data_q <= 1'b0;
      dir_q      <= 1'b0;
      blocks_q   <= BLK_ZERO;
      err_q      <= 3'b000;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
      has_data_q <= has_data_d;
      dir_q      <= dir_d;
      blocks_q   <= blocks_d;
      err_q      <= err_d;
    end
  end

`ifdef AUTO_CMD12_EN
  // Remembers whether the current transfer ends with an automatic CMD12.
  always_ff @(posedge host_clk or negedge rst_L) begin
    if (!rst_L) begin
      auto_stop_q <= 1'b0;
    end else begin
      auto_stop_q <= auto_stop_d;
    end
  end
`endif

  // Output strobes; data init and done pulses appear the cycle after their state.
  always_ff @(posedge host_clk or negedge rst_L) begin
    if (!rst_L) begin
      cmd_issue_q  <= 1'b0;
      tx_init_q    <= 1'b0;
      rx_init_q    <= 1'b0;
      inhibit_q    <= 1'b0;
      dat_active_q <= 1'b0;
      xfer_done_q  <= 1'b0;
      gap_evt_q    <= 1'b0;
    end else begin
      cmd_issue_q  <= issue_s;
      tx_init_q    <= (state_q == S_DAT_START) && !dir_q;
      rx_init_q    <= (state_q == S_DAT_START) && dir_q;
      inhibit_q    <= (state_d != S_IDLE);
      dat_active_q <= is_dat_state(state_d);
      xfer_done_q  <= (state_q == S_DONE);
      gap_evt_q    <= (state_q == S_DAT_WAIT) && (state_d == S_GAP);
    end
  end

  assign cmd_issue     = cmd_issue_q;
  assign cmd_index_out = idx_q;
  assign cmd_arg_out   = arg_q;
  assign tx_data_init  = tx_init_q;
  assign rx_data_init  = rx_init_q;
  assign cmd_inhibit   = inhibit_q;
  assign dat_active    = dat_active_q;
  assign blocks_left   = blocks_q;
  assign xfer_done     = xfer_done_q;
  assign gap_evt       = gap_evt_q;
  assign err_code      = err_q;

endmodule

// File: tb/tb_sd_xfer_sequencer.sv
// Scoreboard bench for sd_xfer_sequencer: a reactive driver pushes expected events, a monitor pops and compares.
module tb_sd_xfer_sequencer;

  localparam int TMO = 64;
  localparam int EV_CMD = 0, EV_RX = 1, EV_TX = 2, EV_GAP = 3, EV_DONE = 4, EV_END = 5;

  typedef struct {
    int          kind;
    int          due;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [15:0] left;
    logic [2:0]  err;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  logic        host_clk, rst_L, start, has_data, dir_read, multi_blk;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [15:0] block_cnt;
  logic        stop_at_gap, continue_req, cmd_complete, cmd_timeout, dat_blk_done, dat_crc_err;
  logic        cmd_issue, tx_data_init, rx_data_init, cmd_inhibit, dat_active, xfer_done, gap_evt;
  logic [5:0]  cmd_index_out;
  logic [31:0] cmd_arg_out;
  logic [15:0] blocks_left;
  logic [2:0]  err_code;

  // Reference model of what the transaction should look like from outside.
  logic [5:0]  m_idx;
  logic [31:0] m_arg;
  int          m_left;
  logic [2:0]  m_err;
  logic        prev_inh = 1'b0;

  sd_xfer_sequencer #(.CNT_W(16), .DAT_TMO(TMO)) dut (
    .host_clk(host_clk), .rst_L(rst_L), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .has_data(has_data), .dir_read(dir_read), .multi_blk(multi_blk), .block_cnt(block_cnt),
    .stop_at_gap(stop_at_gap), .continue_req(continue_req), .cmd_complete(cmd_complete),
    .cmd_timeout(cmd_timeout), .dat_blk_done(dat_blk_done), .dat_crc_err(dat_crc_err),
    .cmd_issue(cmd_issue), .cmd_index_out(cmd_index_out), .cmd_arg_out(cmd_arg_out),
    .tx_data_init(tx_data_init), .rx_data_init(rx_data_init), .cmd_inhibit(cmd_inhibit),
    .dat_active(dat_active), .blocks_left(blocks_left), .xfer_done(xfer_done),
    .gap_evt(gap_evt), .err_code(err_code)
  );

  initial host_clk = 1'b0;
  always #5 host_clk = ~host_clk;
  always @(posedge host_clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_CMD:  return "cmd_issue";
      EV_RX:   return "rx_init";
      EV_TX:   return "tx_init";
      EV_GAP:  return "gap_evt";
      EV_DONE: return "xfer_done";
      EV_END:  return "idle_return";
      default: return "none";
    endcase
  endfunction

  task automatic push_ev(input int kind, input int due);
    ev_t e;
    e.kind = kind; e.due = due; e.idx = m_idx; e.arg = m_arg;
    e.left = 16'(m_left); e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: actual event at cyc %0d, required no event", kname(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.due != cyc || e.idx != cmd_index_out || e.arg != cmd_arg_out ||
          e.left != blocks_left || e.err != err_code) begin
        n_fail++;
        $display("FAIL event_%s: actual %s cyc=%0d idx=%0d arg=%h left=%0d err=%b, required %s cyc=%0d idx=%0d arg=%h left=%0d err=%b",
                 kname(e.kind), kname(kind), cyc, cmd_index_out, cmd_arg_out, blocks_left, err_code,
                 kname(e.kind), e.due, e.idx, e.arg, e.left, e.err);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every DUT output event is matched against the head of the scoreboard.
  always @(negedge host_clk) begin
    if (rst_L) begin
      if (cmd_issue)    check_ev(EV_CMD);
      if (rx_data_init) check_ev(EV_RX);
      if (tx_data_init) check_ev(EV_TX);
      if (gap_evt)      check_ev(EV_GAP);
      if (xfer_done)    check_ev(EV_DONE);
      if (prev_inh && !cmd_inhibit) check_ev(EV_END);
    end
    prev_inh = cmd_inhibit;
  end

  task automatic tick;
    @(posedge host_clk);
    #1;
  endtask

  // which: 0 cmd_issue, 1 data init, 2 gap_evt, 3 back to idle.
  task automatic wait_ev(input int which, input int budget, output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge host_clk);
      case (which)
        0:       ok = cmd_issue;
        1:       ok = rx_data_init | tx_data_init;
        2:       ok = gap_evt;
        default: ok = !cmd_inhibit;
      endcase
      at = cyc;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_%0d: actual no event in %0d cycles, required event", which, budget);
    end
  endtask

  task automatic scramble;
    cmd_index = 6'($urandom); cmd_arg = $urandom; has_data = 1'($urandom);
    dir_read = 1'($urandom); multi_blk = 1'($urandom); block_cnt = 16'($urandom);
  endtask

  task automatic clear_pulses;
    start = 1'b0; continue_req = 1'b0; cmd_complete = 1'b0; cmd_timeout = 1'b0;
    dat_blk_done = 1'b0; dat_crc_err = 1'b0;
  endtask

  task automatic run_xact(input logic [5:0] idx, input logic [31:0] arg, input bit hd, input bit dir,
                          input bit multi, input logic [15:0] cnt, input bit cto, input int err_blk,
                          input bit err_tmo, input logic [7:0] gap_mask, input int rst_blk);
    int nblk, at, init_kind;
    bit ok;
    nblk = multi ? int'(cnt) : 1;
    init_kind = dir ? EV_RX : EV_TX;
    m_idx = idx; m_arg = arg; m_left = nblk; m_err = 3'b000;
    cmd_index = idx; cmd_arg = arg; has_data = hd; dir_read = dir; multi_blk = multi; block_cnt = cnt;
    start = 1'b1;
    push_ev(EV_CMD, cyc + 1);
    tick;
    start = 1'b0;
    scramble;
    check_val("inhibit_after_start", {31'd0, cmd_inhibit}, 32'd1);
    wait_ev(0, 20, at, ok);
    if (!ok) return;
    repeat ($urandom_range(1, 6)) tick;
    if (cto) begin
      cmd_timeout = 1'b1;
      cmd_complete = 1'($urandom);
      m_err = 3'b001;
      push_ev(EV_END, cyc + 2);
      tick;
      clear_pulses;
      wait_ev(3, 20, at, ok);
      return;
    end
    cmd_complete = 1'b1;
    if (!(hd && nblk != 0)) begin
      push_ev(EV_DONE, cyc + 2);
      push_ev(EV_END, cyc + 2);
      tick;
      clear_pulses;
      wait_ev(3, 20, at, ok);
      return;
    end
    push_ev(init_kind, cyc + 2);
    tick;
    clear_pulses;
    for (int b = 0; b < nblk; b++) begin
      wait_ev(1, 20, at, ok);
      if (!ok) return;
      if (b == rst_blk) begin
        #2 rst_L = 1'b0;
        #1;
        check_val("rst_cmd_issue", {31'd0, cmd_issue}, 32'd0);
        check_val("rst_inhibit", {31'd0, cmd_inhibit}, 32'd0);
        check_val("rst_dat_active", {31'd0, dat_active}, 32'd0);
        check_val("rst_blocks_left", {16'd0, blocks_left}, 32'd0);
        check_val("rst_index", {26'd0, cmd_index_out}, 32'd0);
        check_val("rst_inits", {30'd0, rx_data_init, tx_data_init}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge host_clk);
        tick;
        rst_L = 1'b1;
        return;
      end
      if (b == err_blk && err_tmo) begin
        m_err = 3'b100;
        push_ev(EV_END, at + TMO + 1);
        wait_ev(3, TMO + 20, at, ok);
        return;
      end
      tick;
      repeat ($urandom_range(0, 8)) tick;
      if (b == err_blk) begin
        dat_crc_err = 1'b1;
        dat_blk_done = 1'($urandom);
        m_err = 3'b010;
        push_ev(EV_END, cyc + 2);
        tick;
        clear_pulses;
        wait_ev(3, 20, at, ok);
        return;
      end
      stop_at_gap = gap_mask[b];
      dat_blk_done = 1'b1;
      m_left = m_left - 1;
      if (m_left == 0) begin
`ifdef AUTO_CMD12_EN
        if (multi) begin
          m_idx = 6'd12; m_arg = 32'h0;
          push_ev(EV_CMD, cyc + 1);
          tick;
          clear_pulses;
          wait_ev(0, 20, at, ok);
          if (!ok) return;
          repeat ($urandom_range(1, 6)) tick;
          cmd_complete = 1'b1;
        end
`endif
        push_ev(EV_DONE, cyc + 2);
        push_ev(EV_END, cyc + 2);
        tick;
        clear_pulses;
        stop_at_gap = 1'b0;
        wait_ev(3, 20, at, ok);
        return;
      end
      if (gap_mask[b]) begin
        push_ev(EV_GAP, cyc + 1);
        tick;
        clear_pulses;
        wait_ev(2, 20, at, ok);
        repeat (4) tick;
        start = 1'b1;
        cmd_index = 6'($urandom);
        tick;
        start = 1'b0;
        repeat (5) tick;
        continue_req = 1'b1;
        push_ev(init_kind, cyc + 2);
        tick;
        continue_req = 1'b0;
        stop_at_gap = 1'b0;
      end else begin
        push_ev(init_kind, cyc + 2);
        tick;
        clear_pulses;
      end
    end
  endtask

  initial begin
    int nb, eb;
    rst_L = 1'b0;
    stop_at_gap = 1'b0;
    clear_pulses;
    scramble;
    #12;
    check_val("reset_cmd_issue", {31'd0, cmd_issue}, 32'd0);
    check_val("reset_inhibit", {31'd0, cmd_inhibit}, 32'd0);
    check_val("reset_dat_active", {31'd0, dat_active}, 32'd0);
    check_val("reset_blocks_left", {16'd0, blocks_left}, 32'd0);
    check_val("reset_err_code", {29'd0, err_code}, 32'd0);
    check_val("reset_cmd_arg", cmd_arg_out, 32'd0);
    check_val("reset_pulses", {28'd0, rx_data_init, tx_data_init, xfer_done, gap_evt}, 32'd0);
    tick;
    rst_L = 1'b1;
    tick;

    run_xact(6'd17, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, -1, 1'b0, 8'h00, -1);
    run_xact(6'd18, 32'h0000_0200, 1'b1, 1'b1, 1'b1, 16'd3, 1'b0, -1, 1'b0, 8'h00, -1);
    run_xact(6'd25, 32'h0000_0400, 1'b1, 1'b0, 1'b1, 16'd4, 1'b0, -1, 1'b0, 8'h02, -1);
    run_xact(6'd17, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 16'd1, 1'b1, -1, 1'b0, 8'h00, -1);
    run_xact(6'd18, 32'h0000_0010, 1'b1, 1'b1, 1'b1, 16'd2, 1'b0, 1, 1'b1, 8'h00, -1);
    run_xact(6'd18, 32'h0000_0020, 1'b1, 1'b1, 1'b1, 16'd0, 1'b0, -1, 1'b0, 8'h00, -1);
    run_xact(6'd25, 32'h0000_0030, 1'b1, 1'b0, 1'b1, 16'd3, 1'b0, 1, 1'b0, 8'h00, -1);
    run_xact(6'd18, 32'h0000_0040, 1'b1, 1'b1, 1'b1, 16'd2, 1'b0, -1, 1'b0, 8'h00, -1);
    run_xact(6'd18, 32'h0000_0050, 1'b1, 1'b1, 1'b1, 16'd3, 1'b0, -1, 1'b0, 8'h00, 1);
    tick;

    for (int i = 0; i < 40; i++) begin
      logic [5:0]  r_idx;
      logic [31:0] r_arg;
      bit          r_hd, r_dir, r_multi;
      logic [15:0] r_cnt;
      r_idx = 6'($urandom); r_arg = $urandom;
      r_hd = ($urandom_range(0, 3) != 0); r_dir = 1'($urandom); r_multi = 1'($urandom);
      r_cnt = 16'($urandom_range(0, 5));
      nb = r_multi ? int'(r_cnt) : 1;
      eb = (($urandom_range(0, 4) == 0) && nb > 0) ? int'($urandom_range(0, nb - 1)) : -1;
      run_xact(r_idx, r_arg, r_hd, r_dir, r_multi, r_cnt, ($urandom_range(0, 7) == 0), eb,
               ($urandom_range(0, 3) == 0), 8'($urandom), -1);
      repeat ($urandom_range(1, 3)) tick;
    end

    repeat (4) tick;
    check_val("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
